// File: rtl/zigzag_buf.sv
// zigzag_buf: ping-pong 8x8 block buffer that accepts one row of 8 signed
// coefficients per cycle and emits them serially in JPEG zigzag order.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high; drops both blocks in flight
//   d[7:0]     one row of coefficients, d[c] is column c
//   d_cnt      row index (0..7) of d
//   d_valid    row on d is valid
//   d_hold     block cannot take a row this cycle (write buffer is full)
//   q          serial coefficient in zigzag order
//   q_idx      zigzag position k (0..63) of q
//   q_last     high when q_idx == 63
//   q_valid    q, q_idx, q_last are valid
//   q_hold     downstream stall
//   state_dbg  output FSM state (0 = IDLE, 1 = SEND)
//
// Handshakes: a row is taken on any rising edge where d_valid & ~d_hold; a
// coefficient is taken on any rising edge where q_valid & ~q_hold. While
// q_valid & q_hold the q-side outputs do not change.
module zigzag_buf #(
  parameter int DW = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] d [7:0],
  input  logic [2:0]           d_cnt,
  input  logic                 d_valid,
  output logic                 d_hold,
  output logic signed [DW-1:0] q,
  output logic [5:0]           q_idx,
  output logic                 q_last,
  output logic                 q_valid,
  input  logic                 q_hold,
  output logic                 state_dbg
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Zigzag position k -> natural index 8*row+col.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic signed [DW-1:0] mem [2][64];
  logic [1:0]           full;
  logic                 wr_sel;
  logic                 rd_sel;
  state_t               state;

  logic                 wr_fire;
  logic                 wr_done;
  logic                 rd_fire;
  logic                 other_ready;
  logic [5:0]           k_next;

  // The write side only ever targets a non-full buffer, so d_hold is simply
  // the full flag of the buffer it points at.
  assign d_hold    = full[wr_sel];
  assign wr_fire   = d_valid & ~d_hold;
  assign wr_done   = wr_fire & (d_cnt == 3'd7);
  assign rd_fire   = q_valid & ~q_hold;
  assign k_next    = q_idx + 6'd1;
  assign state_dbg = (state == SEND);

  // The other buffer counts as ready if it is already full or is being
  // completed on this very edge, so a fill and a release on the same cycle
  // chain without a bubble. Its k=0 entry is row 0, written long before the
  // completing row 7, so reading it on the same edge is safe.
  assign other_ready = full[~rd_sel] | (wr_done & (wr_sel != rd_sel));

  // Buffer storage carries no reset; a discarded block is simply rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < 8; c++) begin
        mem[wr_sel][{d_cnt, 3'(c)}] <= d[c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full    <= 2'b00;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      state   <= IDLE;
      q       <= '0;
      q_idx   <= 6'd0;
      q_last  <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      // Fill and release always touch different buffers.
      if (wr_done) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end

      case (state)
        IDLE: begin
          if (full[rd_sel]) begin
            state   <= SEND;
            q_valid <= 1'b1;
            q_idx   <= 6'd0;
            q_last  <= 1'b0;
            q       <= mem[rd_sel][ZZ[0]];
          end
        end
        SEND: begin
          if (rd_fire) begin
            if (q_idx == 6'd63) begin
              full[rd_sel] <= 1'b0;
              rd_sel       <= ~rd_sel;
              q_idx        <= 6'd0;
              q_last       <= 1'b0;
              if (other_ready) begin
                q <= mem[~rd_sel][ZZ[0]];
              end else begin
                state   <= IDLE;
                q_valid <= 1'b0;
                q       <= '0;
              end
            end else begin
              q      <= mem[rd_sel][ZZ[k_next]];
              q_idx  <= k_next;
              q_last <= (k_next == 6'd63);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_buf.sv
module tb_zigzag_buf;
  localparam int DW = 15;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk;
  logic                 reset;
  logic signed [DW-1:0] d [7:0];
  logic [2:0]           d_cnt;
  logic                 d_valid;
  logic                 d_hold;
  logic signed [DW-1:0] q;
  logic [5:0]           q_idx;
  logic                 q_last;
  logic                 q_valid;
  logic                 q_hold;
  logic                 state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zigzag_buf #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .d_cnt     (d_cnt),
    .d_valid   (d_valid),
    .d_hold    (d_hold),
    .q         (q),
    .q_idx     (q_idx),
    .q_last    (q_last),
    .q_valid   (q_valid),
    .q_hold    (q_hold),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int zz_tab [64];

  logic signed [DW-1:0] exp_q[$];
  logic [5:0]           exp_idx[$];
  logic signed [DW-1:0] got_q[$];
  logic [5:0]           got_idx[$];
  logic                 got_last[$];

  // Held-output watcher state
  bit                   hold_chk = 0;
  logic signed [DW-1:0] h_q;
  logic [5:0]           h_idx;
  logic                 h_last;

  // Collect every transferred coefficient and check that held outputs stay put.
  always @(negedge clk) begin
    if (reset) begin
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        total++;
        if (q !== h_q || q_idx !== h_idx || q_last !== h_last || q_valid !== 1'b1) begin
          bad++;
          $display("FAIL hold_stable: got q=%0d idx=%0d last=%0d valid=%0d, want q=%0d idx=%0d last=%0d valid=1",
                   q, q_idx, q_last, q_valid, h_q, h_idx, h_last);
        end
      end
      if (q_valid && !q_hold) begin
        got_q.push_back(q);
        got_idx.push_back(q_idx);
        got_last.push_back(q_last);
      end
      hold_chk = q_valid && q_hold;
      h_q = q; h_idx = q_idx; h_last = q_last;
    end
  end

  // ---------------- driver / model tasks ----------------
  function automatic void build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_tab[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_tab[n] = r * 8 + (s - r); n++; end
      end
    end
  endfunction

  // Expected zigzag stream of a block whose entry n is base+n, except row
  // alt_row which holds alt_base+n.
  function automatic void push_exp(input int base, input int alt_row, input int alt_base);
    for (int k = 0; k < 64; k++) begin
      int n = zz_tab[k];
      exp_q.push_back(DW'(((n / 8) == alt_row) ? alt_base + n : base + n));
      exp_idx.push_back(6'(k));
    end
  endfunction

  function automatic void clear_queues();
    exp_q.delete(); exp_idx.delete();
    got_q.delete(); got_idx.delete(); got_last.delete();
  endfunction

  // Present row r with entries base+8r+c; returns one cycle after acceptance.
  task automatic put_row(input int base, input int r);
    bit done = 0;
    for (int c = 0; c < 8; c++) d[c] = DW'(base + 8 * r + c);
    d_cnt   = 3'(r);
    d_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      if (!d_hold) done = 1;
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL put_row: row %0d not accepted within 400 cycles, want accepted", r);
    end
  endtask

  task automatic put_block(input int base);
    for (int r = 0; r < 8; r++) put_row(base, r);
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 3000 && got_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (got_q.size() < n) begin
      bad++;
      $display("FAIL wait_got: got %0d coefficients, want %0d", got_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if (d_hold !== 1'b0)     begin bad++; $display("FAIL reset_d_hold: got %0d want 0", d_hold); end
    total++; if (q_valid !== 1'b0)    begin bad++; $display("FAIL reset_q_valid: got %0d want 0", q_valid); end
    total++; if (q_idx !== 6'd0)      begin bad++; $display("FAIL reset_q_idx: got %0d want 0", q_idx); end
    total++; if (q_last !== 1'b0)     begin bad++; $display("FAIL reset_q_last: got %0d want 0", q_last); end
    total++; if (q !== '0)            begin bad++; $display("FAIL reset_q: got %0d want 0", q); end
    total++; if (state_dbg !== 1'b0)  begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_block();
    clear_queues();
    push_exp(0, -1, 0);
    put_block(0);
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL single_latency_early: q_valid=%0d want 0", q_valid); end
    @(posedge clk); #1;
    total++;
    if (q_valid !== 1'b1 || q_idx !== 6'd0 || q !== '0) begin
      bad++;
      $display("FAIL single_first: valid=%0d idx=%0d q=%0d, want valid=1 idx=0 q=0", q_valid, q_idx, q);
    end
    wait_got(64);
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== (exp_idx[i] == 6'd63)) begin
        bad++;
        $display("FAIL single_seq[%0d]: got q=%0d idx=%0d last=%0d, want q=%0d idx=%0d last=%0d",
                 i, got_q[i], got_idx[i], got_last[i], exp_q[i], exp_idx[i], exp_idx[i] == 6'd63);
      end
    end
    repeat (4) @(posedge clk); #1;
    total++;
    if (q_valid !== 1'b0 || got_q.size() != 64) begin
      bad++;
      $display("FAIL single_end: valid=%0d count=%0d, want valid=0 count=64", q_valid, got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    clear_queues();
    push_exp(100, -1, 0); push_exp(-2000, -1, 0); push_exp(3000, -1, 0);
    fork
      begin
        put_block(100);
        put_block(-2000);
        total++; if (d_hold !== 1'b1) begin bad++; $display("FAIL b2b_hold_on: d_hold=%0d want 1", d_hold); end
        for (int i = 0; i < 200 && d_hold; i++) begin @(posedge clk); #1; end
        total++;
        if (got_q.size() != 64) begin
          bad++;
          $display("FAIL b2b_hold_release: d_hold dropped after %0d outputs, want 64", got_q.size());
        end
        put_block(3000);
      end
      begin
        for (int i = 0; i < 200 && got_q.size() == 0; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 400 && got_q.size() < 192; i++) begin
          @(posedge clk); #1;
          if (got_q.size() < 192 && !q_valid) gaps++;
        end
        total++;
        if (gaps != 0) begin bad++; $display("FAIL b2b_gap: %0d idle cycles, want 0", gaps); end
      end
    join
    wait_got(192);
    for (int i = 0; i < 192; i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== (exp_idx[i] == 6'd63)) begin
        bad++;
        $display("FAIL b2b_seq[%0d]: got q=%0d idx=%0d last=%0d, want q=%0d idx=%0d",
                 i, got_q[i], got_idx[i], got_last[i], exp_q[i], exp_idx[i]);
      end
    end
  endtask

  task automatic test_random_hold();
    clear_queues();
    push_exp(7, -1, 0); push_exp(-77, -1, 0); push_exp(1234, -1, 0); push_exp(-4321, -1, 0);
    fork
      begin
        put_block(7); put_block(-77); put_block(1234); put_block(-4321);
      end
      begin
        for (int i = 0; i < 4000 && got_q.size() < 256; i++) begin
          @(posedge clk); #1;
          q_hold = 1'($urandom_range(0, 1));
        end
        q_hold = 1'b0;
      end
    join
    wait_got(256);
    repeat (4) @(posedge clk); #1;
    total++;
    if (got_q.size() != 256) begin bad++; $display("FAIL rand_count: got %0d want 256", got_q.size()); end
    for (int i = 0; i < 256; i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== (exp_idx[i] == 6'd63)) begin
        bad++;
        $display("FAIL rand_seq[%0d]: got q=%0d idx=%0d last=%0d, want q=%0d idx=%0d",
                 i, got_q[i], got_idx[i], got_last[i], exp_q[i], exp_idx[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    clear_queues();
    push_exp(11, -1, 0); push_exp(-500, -1, 0); push_exp(2500, -1, 0);
    put_block(11);
    for (int r = 0; r < 7; r++) put_row(-500, r);
    for (int i = 0; i < 200 && !(q_valid && q_idx == 6'd63); i++) begin @(posedge clk); #1; end
    total++;
    if (!(q_valid && q_idx == 6'd63) || d_hold !== 1'b0) begin
      bad++;
      $display("FAIL simul_setup: valid=%0d idx=%0d d_hold=%0d, want valid=1 idx=63 d_hold=0", q_valid, q_idx, d_hold);
    end
    put_row(-500, 7);
    total++;
    if (q_valid !== 1'b1 || q_idx !== 6'd0 || q !== DW'(-500)) begin
      bad++;
      $display("FAIL simul_next: valid=%0d idx=%0d q=%0d, want valid=1 idx=0 q=-500", q_valid, q_idx, q);
    end
    total++; if (d_hold !== 1'b0) begin bad++; $display("FAIL simul_d_hold: got %0d want 0", d_hold); end
    put_block(2500);
    wait_got(192);
    for (int i = 0; i < 192; i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== (exp_idx[i] == 6'd63)) begin
        bad++;
        $display("FAIL simul_seq[%0d]: got q=%0d idx=%0d last=%0d, want q=%0d idx=%0d",
                 i, got_q[i], got_idx[i], got_last[i], exp_q[i], exp_idx[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    put_block(40);
    for (int r = 0; r < 4; r++) put_row(-60, r);
    for (int i = 0; i < 200 && !(q_valid && q_idx == 6'd20); i++) begin @(posedge clk); #1; end
    total++;
    if (q_idx !== 6'd20) begin bad++; $display("FAIL rstmid_setup: idx=%0d want 20", q_idx); end
    for (int c = 0; c < 8; c++) d[c] = DW'(-60 + 32 + c);
    d_cnt = 3'd4; d_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++;
    if (q_valid !== 1'b0 || d_hold !== 1'b0 || q_idx !== 6'd0 || q_last !== 1'b0 || q !== '0) begin
      bad++;
      $display("FAIL rstmid_now: valid=%0d d_hold=%0d idx=%0d last=%0d q=%0d, want all 0",
               q_valid, d_hold, q_idx, q_last, q);
    end
    d_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_queues();
    repeat (3) @(posedge clk); #1;
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL rstmid_idle: valid=%0d want 0", q_valid); end
    push_exp(900, -1, 0);
    put_block(900);
    wait_got(64);
    repeat (4) @(posedge clk); #1;
    total++;
    if (got_q.size() != 64) begin bad++; $display("FAIL rstmid_count: got %0d want 64", got_q.size()); end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== (exp_idx[i] == 6'd63)) begin
        bad++;
        $display("FAIL rstmid_seq[%0d]: got q=%0d idx=%0d last=%0d, want q=%0d idx=%0d",
                 i, got_q[i], got_idx[i], got_last[i], exp_q[i], exp_idx[i]);
      end
    end
  endtask

  task automatic test_repeat_row();
    clear_queues();
    push_exp(-1000, 1, 6000);
    put_row(-1000, 0);
    put_row(-1000, 1);
    put_row(6000, 1);
    for (int r = 2; r < 7; r++) put_row(-1000, r);
    repeat (2) @(posedge clk); #1;
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL repeat_early: valid=%0d want 0", q_valid); end
    put_row(-1000, 7);
    wait_got(64);
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== (exp_idx[i] == 6'd63)) begin
        bad++;
        $display("FAIL repeat_seq[%0d]: got q=%0d idx=%0d last=%0d, want q=%0d idx=%0d",
                 i, got_q[i], got_idx[i], got_last[i], exp_q[i], exp_idx[i]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset   = 1'b1;
    d_valid = 1'b0;
    d_cnt   = 3'd0;
    q_hold  = 1'b0;
    for (int c = 0; c < 8; c++) d[c] = '0;
    build_zz();
    @(posedge clk); #1;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_random_hold();
    test_simultaneous();
    test_reset_mid();
    test_repeat_row();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
